assoc_cache: RTL

// Parametrised N-way set-associative write-back, write-allocate data cache for the MIPS core.

---
 rtl/assoc_cache.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative write-back/write-allocate data cache, LRU by per-line tick.
// Define CACHE_STATS_EN to add the hit_count/miss_count outputs.
module assoc_cache #(
  parameter int SETS       = 4,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        ready,
  input  logic        write_en,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic        hit,
  output logic [31:0] out,
  output logic        mwrite_en,
  output logic [31:0] maddr,
  output logic [31:0] mdata,
  input  logic [31:0] mout
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int WBITS = $clog2(LINE_WORDS);
  localparam int IBITS = $clog2(SETS);
  localparam int OBITS = 2 + WBITS;
  localparam int TW    = 32 - OBITS - IBITS;
  localparam int CW    = (WBITS > 0) ? WBITS : 1;
  localparam int IW    = (IBITS > 0) ? IBITS : 1;
  localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   now_q;

  logic          valid_q [SETS][WAYS];
  logic          dirty_q [SETS][WAYS];
  logic [TW-1:0] tag_q   [SETS][WAYS];
  logic [31:0]   tick_q  [SETS][WAYS];
  logic [31:0]   data_q  [SETS][WAYS][LINE_WORDS];

  logic [WW-1:0] vic_q;
  logic [TW-1:0] vtag_q;
  logic [TW-1:0] rtag_q;
  logic [IW-1:0] ridx_q;

  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic [CW-1:0] req_word;
  logic          any_hit;
  logic [WW-1:0] hit_way;
  logic          inv_found;
  logic [WW-1:0] vic;
  logic [31:0]   best;
  logic          vic_dirty;
  logic          miss_go;
  logic          last;

  assign req_idx  = IW'((addr >> OBITS) & 32'(SETS - 1));
  assign req_tag  = TW'(addr >> (OBITS + IBITS));
  assign req_word = CW'((addr >> 2) & 32'(LINE_WORDS - 1));
  assign last     = (count_q == CW'(LINE_WORDS - 1));

  function automatic logic [31:0] line_addr(
    input logic [TW-1:0] t,
    input logic [IW-1:0] s,
    input logic [CW-1:0] c
  );
    return (32'(t) << (OBITS + IBITS)) | (32'(s) << OBITS) | (32'(c) << 2);
  endfunction

  always_comb begin
    any_hit = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!any_hit && valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
        any_hit = 1'b1;
        hit_way = WW'(w);
      end
    end
  end

  // Prefer an empty way; otherwise oldest tick, ties to the lowest way.
  always_comb begin
    inv_found = 1'b0;
    vic       = '0;
    best      = tick_q[req_idx][0];
    for (int w = 0; w < WAYS; w++) begin
      if (!inv_found && !valid_q[req_idx][w]) begin
        inv_found = 1'b1;
        vic       = WW'(w);
      end
    end
    if (!inv_found) begin
      for (int w = 1; w < WAYS; w++) begin
        if (tick_q[req_idx][w] < best) begin
          best = tick_q[req_idx][w];
          vic  = WW'(w);
        end
      end
    end
  end

  assign vic_dirty = valid_q[req_idx][vic] && dirty_q[req_idx][vic];
  assign miss_go   = (state_q == IDLE) && ready && !any_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      now_q   <= '0;
    end else if (en) begin
      state_q <= state_d;
      count_q <= count_d;
      now_q   <= now_q + 32'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (miss_go) begin
          state_d = vic_dirty ? WRITEBACK : REFILL;
          count_d = '0;
        end
      end
      WRITEBACK: begin
        if (last) begin
          state_d = REFILL;
          count_d = '0;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      REFILL: begin
        if (last) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_comb begin
    hit       = 1'b0;
    out       = '0;
    mwrite_en = 1'b0;
    maddr     = '0;
    mdata     = '0;
    unique case (state_q)
      IDLE: begin
        hit = ready && any_hit;
        if (ready && any_hit && !write_en) begin
          out = data_q[req_idx][hit_way][req_word];
        end
      end
      WRITEBACK: begin
        mwrite_en = en;
        maddr     = line_addr(vtag_q, ridx_q, count_q);
        mdata     = data_q[ridx_q][vic_q][count_q];
      end
      REFILL: begin
        maddr = line_addr(rtag_q, ridx_q, count_q);
      end
      default: begin
        hit = 1'b0;
      end
    endcase
  end

  // Victim is invalidated at miss time so an interrupted fill never leaves a stale line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vic_q  <= '0;
      vtag_q <= '0;
      rtag_q <= '0;
      ridx_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          tick_q[s][w]  <= '0;
          for (int k = 0; k < LINE_WORDS; k++) begin
            data_q[s][w][k] <= '0;
          end
        end
      end
    end else if (en) begin
      unique case (state_q)
        IDLE: begin
          if (ready && any_hit) begin
            tick_q[req_idx][hit_way] <= now_q;
            if (write_en) begin
              data_q[req_idx][hit_way][req_word] <= data;
              dirty_q[req_idx][hit_way]          <= 1'b1;
            end
          end else if (miss_go) begin
            vic_q                 <= vic;
            vtag_q                <= tag_q[req_idx][vic];
            rtag_q                <= req_tag;
            ridx_q                <= req_idx;
            valid_q[req_idx][vic] <= 1'b0;
          end
        end
        REFILL: begin
          data_q[ridx_q][vic_q][count_q] <= mout;
          if (last) begin
            valid_q[ridx_q][vic_q] <= 1'b1;
            dirty_q[ridx_q][vic_q] <= 1'b0;
            tag_q[ridx_q][vic_q]   <= rtag_q;
          end
        end
        default: begin
          vic_q <= vic_q;
        end
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (en) begin
      if (hit) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (miss_go) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
